alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//   Execution-side consumer of the 4-bit ALU control code. Accepts an operand pair
//   plus ALUCtrl over a valid/ready handshake and computes the result and flags.
//   Results are held in a 2-entry output FIFO, so a stalled downstream stage
//   (MEM/WB) back-pressures EX without losing results.
//   Sits between alu_control/ID-EX register and the EX-MEM pipeline register.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>= 2)
// PORTS
//   clk          in   1      clock, all state updates on rising edge
//   reset        in   1      synchronous, active-high reset
//   in_valid     in   1      operand/control presented
//   in_ready     out  1      block can accept this cycle
//   in_ctrl      in   4      ALUCtrl code
//   in_a         in   WIDTH  operand A
//   in_b         in   WIDTH  operand B
//   out_valid    out  1      FIFO head holds a result
//   out_ready    in   1      downstream takes head this cycle
//   out_result   out  WIDTH  head result
//   out_zero     out  1      head result == 0
//   out_ovf      out  1      signed overflow (ADD/SUB only, else 0)
//   out_illegal  out  1      head came from an undefined ctrl code
//   op_count     out  16     number of accepted ops, wraps 0xFFFF->0
// BEHAVIOUR
//   Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0/1),
//     1100 NOR, 1101 XOR. Any other code: result 0, zero=1, ovf=0, illegal=1.
//   Arithmetic modulo 2^WIDTH. ADD ovf = a,b same sign and sum sign differs.
//     SUB ovf = a,b signs differ and diff sign != a sign.
//     SLT uses the true signed compare (a-b sign XOR ovf), never raw diff sign.
//   Accept: in_valid && in_ready at edge. Result+flags computed combinationally,
//     written into FIFO tail at that same edge. Latency 1 cycle: if FIFO was empty,
//     out_valid=1 the next cycle.
//   Pop: out_valid && out_ready at edge removes head.
//   FIFO count 0..2. in_ready = (count < 2), registered state only; no
//     combinational path from out_ready to in_ready.
//   Push+pop same edge: count unchanged, order preserved (head pops, new goes tail).
//   count==2: in_ready=0. Inputs ignored even if in_valid=1. op_count frozen.
//   out_valid=0: out_result/flags hold the last-popped value (0 after reset); the
//     bench must not check them.
//   Input must stay stable only in the accept cycle. The block keeps no other
//     input dependency.
//   Reset (any cycle, including mid-stream with a full FIFO): count=0, out_valid=0,
//     in_ready=1 in the next cycle. out_result=0, flags=0, op_count=0. Buffered
//     results are discarded. An in_valid asserted during the reset cycle is not
//     accepted.
//   op_count increments on each accept. Throughput 1 op/cycle while out_ready=1.
// TESTING
//   1. Reset, ADD a=5 b=7, out_ready=1 -> next cycle out_valid=1, result=12,
//      zero=0, ovf=0, op_count=1.
//   2. ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1. SUB 0x80000000-1 -> 0x7FFFFFFF,
//      ovf=1. SLT 0x80000000,1 -> 1. SLT 1,0x80000000 -> 0.
//   3. out_ready=0, issue 3 ops back-to-back -> first 2 accepted, in_ready=0 from
//      cycle 2, 3rd held. Raise out_ready -> results in issue order, 3rd accepted
//      1 cycle after the first pop.
//   4. Streaming 100 random ops with out_ready=1 -> in_ready stays 1, one result
//      per cycle, all match the golden model, op_count=100.
//   5. ctrl=1010, a=3, b=3 -> result=0, zero=1, illegal=1. SUB 9-9 -> zero=1,
//      illegal=0.
//   6. Fill FIFO (count=2), assert reset 1 cycle -> out_valid=0, in_ready=1,
//      op_count=0. Stale results are never presented.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: EX-stage ALU behind a valid/ready input, with a 2-entry result FIFO.
// The FIFO head lives in the output registers and a single skid register holds
// the second entry, so every output is driven directly by a flop.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [15:0]      op_count
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_XOR = 4'b1101;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;
  logic             w_zero;
  logic             w_push;
  logic             w_pop;

  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_out_res;
  logic             r_out_zero;
  logic             r_out_ovf;
  logic             r_out_ill;
  logic [WIDTH-1:0] r_skid_res;
  logic             r_skid_zero;
  logic             r_skid_ovf;
  logic             r_skid_ill;
  logic [15:0]      r_op_count;

  // Datapath: compute result and flags for the operands currently presented.
  always_comb begin
    w_sum     = in_a + in_b;
    w_diff    = in_a - in_b;
    w_add_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
    w_sub_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
    w_res     = {WIDTH{1'b0}};
    w_ovf     = 1'b0;
    w_ill     = 1'b0;
    case (in_ctrl)
      C_AND: w_res = in_a & in_b;
      C_OR:  w_res = in_a | in_b;
      C_ADD: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      C_SUB: begin
        w_res = w_diff;
        w_ovf = w_sub_ovf;
      end
      // Signed less-than: the raw difference sign is wrong when the subtract overflows.
      C_SLT: w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_sub_ovf};
      C_NOR: w_res = ~(in_a | in_b);
      C_XOR: w_res = in_a ^ in_b;
      default: begin
        w_res = {WIDTH{1'b0}};
        w_ill = 1'b1;
      end
    endcase
    w_zero = (w_res == {WIDTH{1'b0}});
  end

  assign in_ready    = (r_count != 2'd2);
  assign out_valid   = (r_count != 2'd0);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;
  assign out_result  = r_out_res;
  assign out_zero    = r_out_zero;
  assign out_ovf     = r_out_ovf;
  assign out_illegal = r_out_ill;
  assign op_count    = r_op_count;

  // FIFO state: head in output regs, second entry in skid regs; pop leaves head stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 2'd0;
      r_out_res   <= {WIDTH{1'b0}};
      r_out_zero  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_ill   <= 1'b0;
      r_skid_res  <= {WIDTH{1'b0}};
      r_skid_zero <= 1'b0;
      r_skid_ovf  <= 1'b0;
      r_skid_ill  <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_out_res  <= w_res;
            r_out_zero <= w_zero;
            r_out_ovf  <= w_ovf;
            r_out_ill  <= w_ill;
            r_count    <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_out_res  <= w_res;
            r_out_zero <= w_zero;
            r_out_ovf  <= w_ovf;
            r_out_ill  <= w_ill;
          end else if (w_push) begin
            r_skid_res  <= w_res;
            r_skid_zero <= w_zero;
            r_skid_ovf  <= w_ovf;
            r_skid_ill  <= w_ill;
            r_count     <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_out_res  <= r_skid_res;
            r_out_zero <= r_skid_zero;
            r_out_ovf  <= r_skid_ovf;
            r_out_ill  <= r_skid_ill;
            r_count    <= 2'd1;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  // Accepted-operation counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_count <= 16'd0;
    end else if (w_push) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed scoreboard bench for alu_exec.
module tb_alu_exec;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        i;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_ctrl = 4'b0000;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic        out_illegal;
  logic [15:0] op_count;

  int   checks = 0;
  int   failures = 0;
  int   results_seen = 0;
  exp_t exp_q[$];

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_illegal(out_illegal), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic o, input logic i);
    exp_t e;
    e.res = r; e.z = z; e.o = o; e.i = i;
    return e;
  endfunction

  // Reference model using wide signed arithmetic for overflow and compare.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic o, il;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; o = 1'b0; il = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = sa + sb; r = a + b; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sa - sb; r = a - b; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b1101: r = a ^ b;
      default: il = 1'b1;
    endcase
    return mk(r, (r == 32'd0), o, il);
  endfunction

  // Monitor: every handshake-completing head is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        results_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got 0x%08h expected no output", out_result);
        end else begin
          e = exp_q.pop_front();
          chk("result", out_result, e.res);
          chk("flags_zoi", {29'd0, out_zero, out_ovf, out_illegal}, {29'd0, e.z, e.o, e.i});
        end
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int waited;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout: in_ready=%0d required 1", in_ready);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b1; in_ctrl = 4'b0010; in_a = 32'd1; in_b = 32'd1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {29'd0, out_zero, out_ovf, out_illegal}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int oc;
    int seen0;
    logic [3:0] codes [8];
    logic [3:0] c;
    logic [31:0] a, b;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1011};

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    out_ready = 1'b1;

    // 1: simple ADD with 1-cycle latency
    issue(4'b0010, 32'd5, 32'd7, mk(32'd12, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_op_count", {16'd0, op_count}, 32'd1);

    // 2: overflow and signed compare corners
    issue(4'b0010, 32'h7FFFFFFF, 32'h00000001, mk(32'h80000000, 1'b0, 1'b1, 1'b0));
    issue(4'b0110, 32'h80000000, 32'h00000001, mk(32'h7FFFFFFF, 1'b0, 1'b1, 1'b0));
    issue(4'b0111, 32'h80000000, 32'h00000001, mk(32'h00000001, 1'b0, 1'b0, 1'b0));
    issue(4'b0111, 32'h00000001, 32'h80000000, mk(32'h00000000, 1'b1, 1'b0, 1'b0));

    // 5: illegal code and zero flag
    issue(4'b1010, 32'd3, 32'd3, mk(32'd0, 1'b1, 1'b0, 1'b1));
    issue(4'b0110, 32'd9, 32'd9, mk(32'd0, 1'b1, 1'b0, 1'b0));
    issue(4'b1100, 32'h0F0F0F0F, 32'h00FF00FF, mk(32'hF000F000, 1'b0, 1'b0, 1'b0));
    drain();

    // 3: back-pressure with three back-to-back ops
    out_ready = 1'b0;
    oc = op_count;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ctrl = 4'b0010; in_a = 32'd1; in_b = 32'd2;
    exp_q.push_back(mk(32'd3, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("t3_ready_c0", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_ctrl = 4'b0001; in_a = 32'h000000F0; in_b = 32'h0000000F;
    exp_q.push_back(mk(32'h000000FF, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("t3_ready_c1", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_ctrl = 4'b1101; in_a = 32'h000000FF; in_b = 32'h0000000F;
    @(negedge clk);
    chk("t3_ready_full", {31'd0, in_ready}, 32'd0);
    chk("t3_opcount_frozen", {16'd0, op_count}, oc + 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_ready_held", {31'd0, in_ready}, 32'd0);
    chk("t3_opcount_held", {16'd0, op_count}, oc + 2);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_ready_before_pop", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_ready_after_pop", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(mk(32'h000000F0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_opcount_final", {16'd0, op_count}, oc + 3);
    drain();

    // 4: streaming 100 ops at full throughput
    do_reset();
    out_ready = 1'b1;
    seen0 = results_seen;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      c = codes[$urandom_range(7, 0)];
      a = $urandom();
      b = $urandom();
      if (i % 10 == 3) a = 32'h80000000;
      if (i % 10 == 7) b = a;
      in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b;
      exp_q.push_back(model(c, a, b));
      @(negedge clk);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("t4_op_count", {16'd0, op_count}, 32'd100);
    chk("t4_results", results_seen - seen0, 32'd100);

    // 6: reset with a full FIFO discards buffered results
    out_ready = 1'b0;
    issue(4'b0010, 32'd10, 32'd20, mk(32'd30, 1'b0, 1'b0, 1'b0));
    issue(4'b0000, 32'hFF00FF00, 32'h0FF00FF0, mk(32'h0F000F00, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("t6_full_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
